// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit scheduler.
package serial_pkg;

    localparam logic [7:0] COMMA_BYTE = 8'hBC;
    localparam int         NUM_LANES  = 4;
    localparam int         LANE_W     = 2;

    typedef enum logic {SYNC, RUN} state_t;

    typedef logic [NUM_LANES-1:0][7:0] lane_bytes_t;

endpackage

// File: rtl/serial_rr_arb.sv
// Lane arbiter: round-robin when SERIAL_TX_RR_EN is defined, otherwise fixed
// priority (lowest lane wins, no pointer state).
module serial_rr_arb
    import serial_pkg::*;
(
`ifdef SERIAL_TX_RR_EN
    input  logic                 clk_4f,
    input  logic                 reset,
`endif
    input  logic                 en,
    input  logic [NUM_LANES-1:0] req,
    output logic [NUM_LANES-1:0] gnt_oh,
    output logic [LANE_W-1:0]    gnt_idx
);

    logic found;

`ifdef SERIAL_TX_RR_EN
    logic [LANE_W-1:0] ptr;
    logic [LANE_W-1:0] cand;

    // Search starts one past the last winner and wraps through all lanes.
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = ptr + LANE_W'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset)
            ptr <= LANE_W'(NUM_LANES - 1);
        else if (|gnt_oh)
            ptr <= gnt_idx;
    end
`else
    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (req[i]) begin
                found   = 1'b1;
                gnt_idx = LANE_W'(i);
            end
        end
    end
`endif

    always_comb begin
        gnt_oh = '0;
        if (en && found)
            gnt_oh[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/serial_tx_sched.sv
// Serial transmit scheduler: comma-based link sync, then one lane byte per cycle.
// Arbitration mode selected by SERIAL_TX_RR_EN (round-robin) or default fixed priority.
module serial_tx_sched
    import serial_pkg::*;
#(
    parameter int         SYNC_LEN = 4,
    parameter logic [7:0] COMMA    = COMMA_BYTE
) (
    input  logic                   clk_4f,
    input  logic                   reset,
    input  logic                   link_en,
    input  logic [NUM_LANES-1:0]   req_valid,
    input  logic [NUM_LANES*8-1:0] req_data,
    output logic [NUM_LANES-1:0]   req_ready,
    output logic [7:0]             data_out,
    output logic                   valid_out,
    output logic [LANE_W-1:0]      grant,
    output logic                   sync_done,
    output logic                   err_comma
);

    localparam int CNT_W = $clog2(SYNC_LEN + 1);

    state_t              state;
    logic [CNT_W-1:0]    sync_cnt;
    logic [NUM_LANES-1:0] gnt_oh;
    logic [LANE_W-1:0]   gnt_idx;
    lane_bytes_t         lanes;
    logic [7:0]          sel_byte;
    logic                arb_en;
    logic                xfer;

    assign lanes     = req_data;
    assign sel_byte  = lanes[gnt_idx];
    assign arb_en    = (state == RUN) && link_en;
    assign req_ready = gnt_oh;
    assign xfer      = |gnt_oh;

    serial_rr_arb u_arb (
`ifdef SERIAL_TX_RR_EN
        .clk_4f  (clk_4f),
        .reset   (reset),
`endif
        .en      (arb_en),
        .req     (req_valid),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    // Every non-payload cycle drives COMMA; payload only replaces it on a clean transfer.
    always_ff @(posedge clk_4f or posedge reset) begin
        if (reset) begin
            state     <= SYNC;
            sync_cnt  <= '0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            grant     <= '0;
            sync_done <= 1'b0;
            err_comma <= 1'b0;
        end else begin
            data_out  <= COMMA;
            valid_out <= 1'b0;
            err_comma <= 1'b0;
            if (!link_en) begin
                state     <= SYNC;
                sync_cnt  <= '0;
                sync_done <= 1'b0;
            end else begin
                case (state)
                    SYNC: begin
                        if (sync_cnt == CNT_W'(SYNC_LEN - 1)) begin
                            state     <= RUN;
                            sync_cnt  <= '0;
                            sync_done <= 1'b1;
                        end else begin
                            sync_cnt <= sync_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (xfer) begin
                            // A comma offered as payload is swallowed and flagged.
                            if (sel_byte == COMMA) begin
                                err_comma <= 1'b1;
                            end else begin
                                data_out  <= sel_byte;
                                valid_out <= 1'b1;
                                grant     <= gnt_idx;
                            end
                        end
                    end
                    default: state <= SYNC;
                endcase
            end
        end
    end

endmodule
